// File: rtl/wr_rd_ram.sv
// Single-port command-driven RAM: 2**ADW words, sync write, registered read.
// Define WR_RD_CLEAR_EN for a flop array that clears to zero on reset.
module wr_rd_ram #(
  parameter int DIW = 16,
  parameter int DOW = 16,
  parameter int ADW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     wr_rd,
  input  logic [DIW-1:0] din,
  input  logic [ADW-1:0] addr,
  output logic [DOW-1:0] dout,
  output logic           rd_vld,
  output logic           err
);

  localparam int DEPTH = 2**ADW;

  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_ILL = 2'b11;

  logic [DIW-1:0] mem [DEPTH];
  logic [DOW-1:0] rd_word;
  logic           is_wr;
  logic           is_rd;
  logic           is_ill;

  // Decode the command bus into one-hot strobes
  always_comb begin
    is_wr  = 1'b0;
    is_rd  = 1'b0;
    is_ill = 1'b0;
    unique case (wr_rd)
      CMD_WR:  is_wr  = 1'b1;
      CMD_RD:  is_rd  = 1'b1;
      CMD_ILL: is_ill = 1'b1;
      default: ;
    endcase
  end

`ifdef WR_RD_CLEAR_EN
  // Flop array: every word clears on reset, written on a write command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (is_wr) begin
      mem[addr] <= din;
    end
  end
`else
  // Inferable RAM: no reset, writes are blocked while reset is held
  always_ff @(posedge clk) begin
    if (rst_n && is_wr) begin
      mem[addr] <= din;
    end
  end
`endif

  generate
    if (DOW > DIW) begin : g_zext
      assign rd_word = {{(DOW-DIW){1'b0}}, mem[addr]};
    end else begin : g_trunc
      assign rd_word = mem[addr][DOW-1:0];
    end
  endgenerate

  // Registered read data plus one-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout   <= '0;
      rd_vld <= 1'b0;
      err    <= 1'b0;
    end else begin
      rd_vld <= is_rd;
      err    <= is_ill;
      if (is_rd) begin
        dout <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_wr_rd_ram.sv
// Self-checking bench for wr_rd_ram: directed vector table,
// reset corner sequences and random traffic against a memory model.
module tb_wr_rd_ram;

  localparam logic [1:0] IDL = 2'b00;
  localparam logic [1:0] RD  = 2'b01;
  localparam logic [1:0] WR  = 2'b10;
  localparam logic [1:0] ILL = 2'b11;

  logic        clk;
  logic        rst_n;
  logic [1:0]  wr_rd;
  logic [15:0] din;
  logic [3:0]  addr;
  logic [15:0] dout;
  logic        rd_vld;
  logic        err;

  int checks;
  int errors;

  typedef struct {
    logic [1:0]  cmd;
    logic [3:0]  a;
    logic [15:0] d;
    logic [15:0] exp_dout;
    logic        exp_vld;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  logic [15:0] mm [16];
  bit          mw [16];
  logic [15:0] edout;
  bit          ek;

  wr_rd_ram #(.DIW(16), .DOW(16), .ADW(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_rd  (wr_rd),
    .din    (din),
    .addr   (addr),
    .dout   (dout),
    .rd_vld (rd_vld),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [15:0] ed,
                         input logic ev, input logic ee);
    chk({nm, ".dout"}, dout, ed);
    chk({nm, ".vld"}, {15'd0, rd_vld}, {15'd0, ev});
    chk({nm, ".err"}, {15'd0, err}, {15'd0, ee});
  endtask

  task automatic drive(input logic [1:0] c, input logic [3:0] a,
                       input logic [15:0] d);
    @(negedge clk);
    wr_rd = c;
    addr  = a;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    wr_rd  = IDL;
    addr   = '0;
    din    = '0;
    rst_n  = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_out("reset", 16'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(IDL, 4'd0, 16'd0);
    chk_out("rel_idle", 16'd0, 1'b0, 1'b0);

    tbl.push_back('{WR,  4'd2, 16'd10, 16'd0,  1'b0, 1'b0});
    tbl.push_back('{WR,  4'd3, 16'd20, 16'd0,  1'b0, 1'b0});
    tbl.push_back('{RD,  4'd2, 16'd0,  16'd10, 1'b1, 1'b0});
    tbl.push_back('{RD,  4'd3, 16'd0,  16'd20, 1'b1, 1'b0});
    tbl.push_back('{WR,  4'd3, 16'd10, 16'd20, 1'b0, 1'b0});
    tbl.push_back('{RD,  4'd3, 16'd0,  16'd10, 1'b1, 1'b0});
    tbl.push_back('{RD,  4'd2, 16'd0,  16'd10, 1'b1, 1'b0});
    tbl.push_back('{ILL, 4'd2, 16'd55, 16'd10, 1'b0, 1'b1});
    tbl.push_back('{IDL, 4'd2, 16'd0,  16'd10, 1'b0, 1'b0});
    tbl.push_back('{WR,  4'd4, 16'd7,  16'd10, 1'b0, 1'b0});
    tbl.push_back('{RD,  4'd4, 16'd0,  16'd7,  1'b1, 1'b0});
    tbl.push_back('{RD,  4'd2, 16'd0,  16'd10, 1'b1, 1'b0});
    tbl.push_back('{RD,  4'd3, 16'd0,  16'd10, 1'b1, 1'b0});
    tbl.push_back('{RD,  4'd3, 16'd0,  16'd10, 1'b1, 1'b0});

    foreach (tbl[i]) begin
      drive(tbl[i].cmd, tbl[i].a, tbl[i].d);
      chk_out($sformatf("vec%0d", i), tbl[i].exp_dout,
              tbl[i].exp_vld, tbl[i].exp_err);
    end

    for (int i = 0; i < 20; i++) begin
      drive(IDL, 4'($urandom_range(0, 15)), 16'($urandom));
      chk_out($sformatf("hold%0d", i), 16'd10, 1'b0, 1'b0);
    end

    drive(RD, 4'd4, 16'd0);
    chk_out("pre_rst_rd", 16'd7, 1'b1, 1'b0);

    @(negedge clk);
    wr_rd = WR;
    addr  = 4'd4;
    din   = 16'd99;
    #2 rst_n = 1'b0;
    #1 chk_out("mid_rst", 16'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 chk_out("rst_edge", 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    wr_rd = IDL;
    rst_n = 1'b1;
    drive(IDL, 4'd0, 16'd0);
    chk_out("post_rst", 16'd0, 1'b0, 1'b0);

`ifdef WR_RD_CLEAR_EN
    drive(RD, 4'd2, 16'd0);
    chk_out("rst_rd2", 16'd0, 1'b1, 1'b0);
    drive(RD, 4'd4, 16'd0);
    chk_out("rst_rd4", 16'd0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      mm[i] = '0;
      mw[i] = 1'b1;
    end
    edout = 16'd0;
`else
    drive(RD, 4'd2, 16'd0);
    chk_out("rst_rd2", 16'd10, 1'b1, 1'b0);
    drive(RD, 4'd4, 16'd0);
    chk_out("rst_rd4", 16'd7, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      mm[i] = '0;
      mw[i] = 1'b0;
    end
    mm[2] = 16'd10; mw[2] = 1'b1;
    mm[3] = 16'd10; mw[3] = 1'b1;
    mm[4] = 16'd7;  mw[4] = 1'b1;
    edout = 16'd7;
`endif
    ek = 1'b1;

    for (int i = 0; i < 400; i++) begin
      logic [1:0]  c;
      logic [3:0]  a;
      logic [15:0] d;
      int r;
      r = int'($urandom_range(0, 9));
      c = (r < 4) ? WR : (r < 8) ? RD : (r < 9) ? IDL : ILL;
      a = 4'($urandom_range(0, 15));
      d = 16'($urandom);
      drive(c, a, d);
      if (c == WR) begin
        mm[a] = d;
        mw[a] = 1'b1;
      end else if (c == RD) begin
        ek    = mw[a];
        edout = mm[a];
      end
      chk($sformatf("rnd%0d.vld", i), {15'd0, rd_vld},
          {15'd0, (c == RD)});
      chk($sformatf("rnd%0d.err", i), {15'd0, err},
          {15'd0, (c == ILL)});
      if (ek) chk($sformatf("rnd%0d.dout", i), dout, edout);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
